// File: rtl/target_round_ctrl.sv
// Game-round sequencer: spawns LFSR-placed targets, qualifies the detector's hit level,
// and keeps score, miss and round counts with a shrinking target size.
module target_round_ctrl #(
  parameter int unsigned TIMEOUT   = 100_000_000,
  parameter int unsigned HIT_HOLD  = 4,
  parameter int unsigned COOLDOWN  = 50_000_000,
  parameter int unsigned ROUNDS    = 10,
  parameter int unsigned X_BASE    = 64,
  parameter int unsigned Y_BASE    = 64,
  parameter int unsigned SIZE_INIT = 50,
  parameter int unsigned SIZE_STEP = 5,
  parameter int unsigned SIZE_MIN  = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        hit,
  output logic [11:0] targetCoord_X,
  output logic [11:0] targetCoord_Y,
  output logic [7:0]  targetSize,
  output logic        target_visible,
  output logic        hitAck,
  output logic [7:0]  score,
  output logic [7:0]  miss_count,
  output logic [7:0]  round,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSpawn  = 3'd1;
  localparam logic [2:0] StActive = 3'd2;
  localparam logic [2:0] StHit    = 3'd3;
  localparam logic [2:0] StMiss   = 3'd4;
  localparam logic [2:0] StCool   = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);
  localparam logic [31:0] HoldLast    = 32'(HIT_HOLD - 1);
  localparam logic [31:0] CoolLast    = 32'(COOLDOWN - 1);
  localparam logic [7:0]  RoundsLast  = 8'(ROUNDS);
  localparam logic [11:0] XBase       = 12'(X_BASE);
  localparam logic [11:0] YBase       = 12'(Y_BASE);
  localparam logic [7:0]  SizeInit    = 8'(SIZE_INIT);
  localparam logic [7:0]  SizeStep    = 8'(SIZE_STEP);
  localparam logic [7:0]  SizeMin     = 8'(SIZE_MIN);
  localparam logic [8:0]  SizeThresh  = 9'(SIZE_MIN + SIZE_STEP);

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [7:0]  size_q, size_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  miss_q, miss_d;
  logic [7:0]  round_q, round_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    x_d     = x_q;
    y_d     = y_q;
    size_d  = size_q;
    score_d = score_q;
    miss_d  = miss_q;
    round_d = round_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          score_d = '0;
          miss_d  = '0;
          round_d = '0;
          size_d  = SizeInit;
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        x_d     = XBase + {3'b000, lfsr_q[8:0]};
        y_d     = YBase + {4'b0000, lfsr_q[15:8]};
        round_d = round_q + 8'd1;
        timer_d = '0;
        hold_d  = '0;
        state_d = StActive;
      end
      StActive: begin
        timer_d = timer_q + 32'd1;
        hold_d  = hit ? hold_q + 32'd1 : 32'd0;
        // A qualifying hit on the final timeout cycle takes priority over the miss.
        if (hit && (hold_q == HoldLast)) begin
          state_d = StHit;
        end else if (timer_q == TimeoutLast) begin
          state_d = StMiss;
        end
      end
      StHit: begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        // Compare before subtracting so the size never wraps below the floor.
        if ({1'b0, size_q} < SizeThresh) size_d = SizeMin;
        else                             size_d = size_q - SizeStep;
        timer_d = '0;
        state_d = StCool;
      end
      StMiss: begin
        if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        timer_d = '0;
        state_d = StCool;
      end
      StCool: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == CoolLast) state_d = (round_q == RoundsLast) ? StDone : StSpawn;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= SizeInit;
      score_q <= '0;
      miss_q  <= '0;
      round_q <= '0;
      timer_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      round_q <= round_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
    end
  end

  assign targetCoord_X  = x_q;
  assign targetCoord_Y  = y_q;
  assign targetSize     = size_q;
  assign score          = score_q;
  assign miss_count     = miss_q;
  assign round          = round_q;
  assign target_visible = (state_q == StActive);
  assign hitAck         = (state_q == StHit);
  assign done           = (state_q == StDone);
  assign busy           = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_target_round_ctrl.sv
// Directed bench for target_round_ctrl: one 3-round instance for game flow, one 12-round
// instance for the size floor and coordinate sequence.
module tb_target_round_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_a, hit_a, start_b, hit_b;
  logic [11:0] x_a, y_a, x_b, y_b;
  logic [7:0]  size_a, score_a, miss_a, round_a, size_b, score_b, miss_b, round_b;
  logic        vis_a, ack_a, busy_a, done_a, vis_b, ack_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ref_lfsr, ref_prev;
  bit          brk_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int          size_tab [10] = '{45, 40, 35, 30, 25, 20, 20, 20, 20, 20};

  target_round_ctrl #(
    .TIMEOUT(20), .HIT_HOLD(3), .COOLDOWN(5), .ROUNDS(3)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .hit(hit_a),
    .targetCoord_X(x_a), .targetCoord_Y(y_a), .targetSize(size_a),
    .target_visible(vis_a), .hitAck(ack_a), .score(score_a), .miss_count(miss_a),
    .round(round_a), .busy(busy_a), .done(done_a)
  );

  target_round_ctrl #(
    .TIMEOUT(20), .HIT_HOLD(3), .COOLDOWN(5), .ROUNDS(12)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .hit(hit_b),
    .targetCoord_X(x_b), .targetCoord_Y(y_b), .targetSize(size_b),
    .target_visible(vis_b), .hitAck(ack_b), .score(score_b), .miss_count(miss_b),
    .round(round_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Reference x^16+x^14+x^13+x^11+1 LFSR; ref_prev is the value one edge back.
  always @(posedge clk) begin
    if (!resetn) begin
      ref_lfsr <= 16'hACE1;
      ref_prev <= 16'hACE1;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called in the first ACTIVE cycle, when ref_prev holds the LFSR value seen in SPAWN.
  task automatic check_coords(input string tag, input logic [11:0] x, input logic [11:0] y);
    logic [11:0] ex;
    logic [11:0] ey;
    ex = 12'd64 + {3'b000, ref_prev[8:0]};
    ey = 12'd64 + {4'b0000, ref_prev[15:8]};
    check_eq({tag, "_x"}, 32'(x), 32'(ex));
    check_eq({tag, "_y"}, 32'(y), 32'(ey));
    check_eq({tag, "_x_range"}, 32'(x >= 12'd64 && x <= 12'd575), 1);
    check_eq({tag, "_y_range"}, 32'(y >= 12'd64 && y <= 12'd319), 1);
  endtask

  task automatic wait_vis_b(input string tag);
    int k = 0;
    while (!vis_b && k < 60) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(vis_b), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start_a = 1'b0; hit_a = 1'b0; start_b = 1'b0; hit_b = 1'b0;
    tick(); tick();
    check_eq("rst_x", 32'(x_a), 0);
    check_eq("rst_y", 32'(y_a), 0);
    check_eq("rst_size", 32'(size_a), 50);
    check_eq("rst_vis", 32'(vis_a), 0);
    check_eq("rst_ack", 32'(ack_a), 0);
    check_eq("rst_score", 32'(score_a), 0);
    check_eq("rst_miss", 32'(miss_a), 0);
    check_eq("rst_round", 32'(round_a), 0);
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_done", 32'(done_a), 0);
    check_eq("rst_size_b", 32'(size_b), 50);
    resetn = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy_a), 0);

    // Round 1: clean hit.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_eq("spawn_busy", 32'(busy_a), 1);
    check_eq("spawn_vis", 32'(vis_a), 0);
    tick();
    check_eq("r1_vis", 32'(vis_a), 1);
    check_eq("r1_round", 32'(round_a), 1);
    check_coords("r1", x_a, y_a);
    hit_a = 1'b1; skip(3);
    check_eq("r1_ack", 32'(ack_a), 1);
    check_eq("r1_score_pre", 32'(score_a), 0);
    hit_a = 1'b0; tick();
    check_eq("r1_ack_pulse", 32'(ack_a), 0);
    check_eq("r1_score", 32'(score_a), 1);
    check_eq("r1_size", 32'(size_a), 45);
    for (int i = 0; i < 5; i++) begin
      check_eq("cool_vis", 32'(vis_a), 0);
      check_eq("cool_busy", 32'(busy_a), 1);
      tick();
    end
    check_eq("r2_spawn_round", 32'(round_a), 1);
    tick();
    check_eq("r2_vis", 32'(vis_a), 1);
    check_eq("r2_round", 32'(round_a), 2);
    check_coords("r2", x_a, y_a);

    // Round 2: 1,1,0 repeated never qualifies; start pulse while busy is ignored.
    for (int i = 0; i < 20; i++) begin
      hit_a = (i % 3 != 2);
      start_a = (i == 4);
      check_eq("r2_active_vis", 32'(vis_a), 1);
      check_eq("r2_no_ack", 32'(ack_a), 0);
      tick();
    end
    hit_a = 1'b0; start_a = 1'b0;
    check_eq("r2_miss_vis", 32'(vis_a), 0);
    check_eq("r2_miss_ack", 32'(ack_a), 0);
    check_eq("r2_miss_pre", 32'(miss_a), 0);
    check_eq("r2_round_kept", 32'(round_a), 2);
    tick();
    check_eq("r2_miss_count", 32'(miss_a), 1);
    check_eq("r2_score", 32'(score_a), 1);
    skip(5);
    check_eq("r3_spawn_vis", 32'(vis_a), 0);
    tick();
    check_eq("r3_vis", 32'(vis_a), 1);
    check_eq("r3_round", 32'(round_a), 3);
    check_coords("r3", x_a, y_a);

    // Round 3: broken hit 1,1,0,1,1,1 scores only after the last three.
    for (int i = 0; i < 6; i++) begin
      hit_a = brk_pat[i];
      check_eq("r3_no_ack", 32'(ack_a), 0);
      tick();
    end
    check_eq("r3_ack", 32'(ack_a), 1);
    hit_a = 1'b0; tick();
    check_eq("r3_score", 32'(score_a), 2);
    check_eq("r3_size", 32'(size_a), 40);
    skip(5);
    check_eq("done", 32'(done_a), 1);
    check_eq("done_busy", 32'(busy_a), 0);
    check_eq("done_score", 32'(score_a), 2);
    check_eq("done_miss", 32'(miss_a), 1);
    check_eq("done_round", 32'(round_a), 3);
    tick();
    check_eq("done_hold", 32'(done_a), 1);
    check_eq("done_round_hold", 32'(round_a), 3);

    // Restart from DONE, then a hit whose third cycle lands on the timeout cycle.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_eq("rs_score", 32'(score_a), 0);
    check_eq("rs_miss", 32'(miss_a), 0);
    check_eq("rs_round", 32'(round_a), 0);
    check_eq("rs_size", 32'(size_a), 50);
    check_eq("rs_done", 32'(done_a), 0);
    check_eq("rs_busy", 32'(busy_a), 1);
    tick();
    check_eq("rs_vis", 32'(vis_a), 1);
    check_coords("rs", x_a, y_a);
    for (int i = 0; i < 20; i++) begin
      hit_a = (i >= 17);
      tick();
    end
    check_eq("tie_ack", 32'(ack_a), 1);
    hit_a = 1'b0; tick();
    check_eq("tie_score", 32'(score_a), 1);
    check_eq("tie_no_miss", 32'(miss_a), 0);

    // Reset in the middle of ACTIVE.
    skip(6);
    check_eq("mid_vis", 32'(vis_a), 1);
    skip(2);
    resetn = 1'b0; tick();
    check_eq("mid_rst_busy", 32'(busy_a), 0);
    check_eq("mid_rst_vis", 32'(vis_a), 0);
    check_eq("mid_rst_score", 32'(score_a), 0);
    check_eq("mid_rst_round", 32'(round_a), 0);
    check_eq("mid_rst_size", 32'(size_a), 50);
    check_eq("mid_rst_x", 32'(x_a), 0);
    resetn = 1'b1; tick();
    check_eq("mid_rst_idle", 32'(busy_a), 0);

    // Size floor and coordinate sequence over 10 consecutive hits.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int r = 0; r < 10; r++) begin
      wait_vis_b("b_active");
      check_coords("b", x_b, y_b);
      hit_b = 1'b1; skip(3);
      check_eq("b_ack", 32'(ack_b), 1);
      hit_b = 1'b0; tick();
      check_eq("b_size", 32'(size_b), 32'(size_tab[r]));
      check_eq("b_score", 32'(score_b), 32'(r + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/target_round_ctrl.md
# target_round_ctrl

Game-round sequencer that drives the hit detector. It places a target at pseudo-random coordinates and gives the player a bounded window to hold the marker on it. It qualifies the detector's `hit` level over several consecutive cycles, acknowledges each qualified hit on `hitAck`, and keeps score and miss counts. Target size shrinks as score rises. The block sits between the marker/target datapath and the VGA renderer / score display.

## Interface
Parameters:
- `TIMEOUT`, 100_000_000: cycles a target stays active before it counts as a miss (≥2).
- `HIT_HOLD`, 4: consecutive `hit` cycles required to score (≥1).
- `COOLDOWN`, 50_000_000: blank cycles between targets (≥1).
- `ROUNDS`, 10: targets per game (1..255).
- `X_BASE`, 64: X offset added to the random X.
- `Y_BASE`, 64: Y offset added to the random Y.
- `SIZE_INIT`, 50: initial `targetSize`.
- `SIZE_STEP`, 5: shrink per scored hit.
- `SIZE_MIN`, 20: floor for `targetSize`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (nonzero).

Ports:
- `clk` in 1: the block's single clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: begin a game; sampled in IDLE or DONE only.
- `hit` in 1: overlap level from the hit detector.
- `targetCoord_X` out 12: current target X.
- `targetCoord_Y` out 12: current target Y.
- `targetSize` out 8: current target size.
- `target_visible` out 1: high while in ACTIVE.
- `hitAck` out 1: one-cycle pulse per scored hit.
- `score` out 8: scored hits, saturating at 255.
- `miss_count` out 8: timed-out targets, saturating at 255.
- `round` out 8: 1-based index of the current target.
- `busy` out 1: high in any state other than IDLE or DONE.
- `done` out 1: high in DONE.

## Operation
- **States:** IDLE, SPAWN, ACTIVE, HIT, MISS, COOL, DONE. All outputs are decoded from registers; there is no combinational path from input to output.
- **Reset** (`resetn`=0 at a `clk` edge, in any state, including mid-round):
  - state←IDLE.
  - Coordinates, `score`, `miss_count`, `round`, `hitAck`, `target_visible`, `busy`, `done` all←0.
  - `targetSize`←SIZE_INIT.
  - LFSR←LFSR_SEED.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Each cycle it shifts left, and bit0 takes lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]. It advances every cycle outside reset and is not reseeded by `start`.
- **IDLE / DONE:** on `start`=1, clear `score`, `miss_count` and `round`, set `targetSize`←SIZE_INIT, then go to SPAWN.
- **SPAWN** (1 cycle):
  - `targetCoord_X`←X_BASE + lfsr[8:0] (zero-extended to 12 bits).
  - `targetCoord_Y`←Y_BASE + lfsr[15:8].
  - `round`←`round`+1.
  - Clear the timer and the hold counter, then go to ACTIVE.
- **ACTIVE:**
  - `timer` increments every cycle.
  - `hold` increments while `hit`=1 and clears when `hit`=0.
  - If `hit`=1 and `hold`==HIT_HOLD-1, go to HIT.
  - Otherwise, if `timer`==TIMEOUT-1, go to MISS.
  - If a qualifying hit occurs on the final timeout cycle, the hit wins.
- **HIT** (1 cycle):
  - `hitAck`=1.
  - `score`←min(`score`+1, 255).
  - `targetSize`←max(`targetSize`−SIZE_STEP, SIZE_MIN). Compute this without unsigned underflow: if `targetSize` < SIZE_MIN+SIZE_STEP, load SIZE_MIN.
  - Go to COOL.
- **MISS** (1 cycle): `miss_count`←min(`miss_count`+1, 255), then go to COOL.
- **COOL:**
  - `target_visible`=0; `hit` is ignored.
  - After exactly COOLDOWN cycles, go to DONE if `round`==ROUNDS, otherwise go to SPAWN.
- **Ignored inputs:** `hit` is ignored outside ACTIVE. `start` is ignored while `busy`=1.
- **Held values:** coordinates hold their value from SPAWN until the next SPAWN. `score`, `miss_count` and `round` hold in DONE.

## Timing
- `start` sampled at edge N → SPAWN during cycle N+1 → ACTIVE from N+2, with new coordinates and `target_visible`=1 visible from N+2.
- **Hit path:**
  - If `hit`=1 for HIT_HOLD consecutive ACTIVE cycles, ending in cycle M, then `hitAck`=1 in cycle M+1 only.
  - The updated `score` and `targetSize` are visible from M+2.
  - The minimum ACTIVE dwell is HIT_HOLD cycles.
- **Miss path:** with no qualifying hit, ACTIVE lasts exactly TIMEOUT cycles, MISS follows for 1 cycle, and `miss_count` updates one cycle after MISS.
- A drop of `hit` for one cycle restarts the hold count from zero.
- **Round period:**
  - Missed target: 1 (SPAWN) + TIMEOUT + 1 + COOLDOWN cycles.
  - Hit target: 1 + HIT_HOLD..TIMEOUT + 1 + COOLDOWN cycles.
- `done` rises on the cycle after the last COOL cycle. In DONE, `start` begins a new game with the same latency as from IDLE.

## Test plan
All scenarios use TIMEOUT=20, HIT_HOLD=3, COOLDOWN=5, ROUNDS=3.
- **Reset values:** hold `resetn`=0 for 2 cycles → all outputs 0, `targetSize`=50, state IDLE. Assert `resetn`=0 mid-ACTIVE → IDLE on the next edge with counters cleared.
- **Clean hit:** `start`, then `hit`=1 for 3 ACTIVE cycles → single `hitAck` pulse, `score`=1, `targetSize`=45, `target_visible`=0 for 5 cycles, `round`=2 after SPAWN.
- **Broken hit:** `hit` pattern 1,1,0,1,1,1 in ACTIVE → `hitAck` only after the final three 1s. A pattern of 1,1,0 repeated → no hit and a miss at cycle 20.
- **Timeout and tie:**
  - Hold `hit`=0 → MISS after exactly 20 ACTIVE cycles, `miss_count`=1.
  - Third consecutive `hit` landing on timer=19 → HIT, not MISS.
- **Full game:** hit, miss, hit → `done`=1, `score`=2, `miss_count`=1, `round`=3. `start` during `busy` is ignored. `start` in DONE clears the counters and restarts.
- **Size floor and LFSR:** 10 consecutive hits with ROUNDS=12 → `targetSize` sequence 45, 40, 35, 30, 25, 20, 20, … Coordinates match a reference LFSR model and stay within [64, 575] for X and [64, 319] for Y.
